// File: rtl/blink_top.sv
`default_nettype none
// ============================================================================
// Module   : blink_top
// Brief    : Free-running LED blinker. A WIDTH-bit counter wraps every
//            CNT_MAX+1 clocks and toggles the registered LED output on each
//            wrap, giving a 50% duty square wave of period 2*(CNT_MAX+1).
// Revision : 1.0 - initial release
// ============================================================================
module blink_top #(
  parameter int               WIDTH   = 26,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] CNT_MAX = WIDTH'(49_999_999)
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  // Power-up values come from the initializers so the block runs correctly
  // even when rst is tied low.
  logic [WIDTH-1:0] cnt_q = INIT;
  logic             led_q = 1'b0;

  logic [WIDTH-1:0] cnt_d;
  logic             led_d;
  logic             w_terminal;

  // Greater-or-equal catches an out-of-range preload so the counter never
  // walks up through 2^WIDTH before wrapping.
  assign w_terminal = (cnt_q >= CNT_MAX);

  // Next-state: wrap and toggle at terminal count, otherwise count up.
  always_comb begin
    cnt_d = cnt_q + C_ONE;
    led_d = led_q;
    if (w_terminal) begin
      cnt_d = C_ZERO;
      led_d = ~led_q;
    end
  end

  // State registers; reset takes priority over wrap and increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_top
// Brief    : Self-checking bench for blink_top. Four instances cover the long
//            default period with a near-terminal preload, a short period with
//            a mid-count reset, an out-of-range preload, and the defaults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_top;

  localparam int          NEDGES = 40;
  localparam logic [25:0] A_INIT = 26'd49_999_990;

  typedef struct {
    int          edge_n;
    logic        la;
    logic [25:0] ca;
    logic        lb;
    logic [25:0] cb;
    logic        lc;
    logic [25:0] cc;
    logic        ld;
    logic [25:0] cd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic led_a, led_b, led_c, led_d;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #2 clk = ~clk;

  blink_top #(.WIDTH(26), .INIT(A_INIT), .CNT_MAX(26'd49_999_999)) u_a (
    .clk(clk), .rst(rst_a), .led(led_a));
  blink_top #(.WIDTH(26), .INIT(26'd0), .CNT_MAX(26'd3)) u_b (
    .clk(clk), .rst(rst_b), .led(led_b));
  blink_top #(.WIDTH(26), .INIT(26'd10), .CNT_MAX(26'd3)) u_c (
    .clk(clk), .rst(1'b0), .led(led_c));
  blink_top u_d (
    .clk(clk), .rst(1'b0), .led(led_d));

  task automatic chk(input string nm, input int e, input logic [25:0] act,
                     input logic [25:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0d expected %0d", nm, e, act, exp);
    end
  endtask

  // Hand-derived expectations: instance A toggles on edge 10, is reset on
  // edges 26-27, and toggles again on the 10th edge after release (edge 37).
  function automatic exp_t expected(input int k);
    exp_t e;
    e.edge_n = k;
    if (k <= 9)       begin e.la = 1'b0; e.ca = A_INIT + 26'(k);      end
    else if (k == 10) begin e.la = 1'b1; e.ca = 26'd0;                end
    else if (k <= 25) begin e.la = 1'b1; e.ca = 26'(k - 10);          end
    else if (k <= 27) begin e.la = 1'b0; e.ca = A_INIT;               end
    else if (k <= 36) begin e.la = 1'b0; e.ca = A_INIT + 26'(k - 27); end
    else              begin e.la = 1'b1; e.ca = 26'(k - 37);          end
    // B: toggles every 4 edges, reset on edge 12 where cnt is at terminal.
    if (k <= 11)       begin e.lb = 1'(((k / 4) % 2));  e.cb = 26'(k % 4);        end
    else if (k == 12)  begin e.lb = 1'b0;               e.cb = 26'd0;             end
    else begin e.lb = 1'(((k - 12) / 4) % 2); e.cb = 26'((k - 12) % 4); end
    // C: preload above terminal toggles on edge 1, then every 4 edges.
    e.lc = 1'(((k + 3) / 4) % 2);
    e.cc = 26'((k - 1) % 4);
    // D: defaults, far from the first toggle.
    e.ld = 1'b0;
    e.cd = 26'(k);
    return e;
  endfunction

  // Monitor: after each rising edge, pop the expected state and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("led_a", e.edge_n, 26'(led_a), 26'(e.la));
        chk("cnt_a", e.edge_n, u_a.cnt_q,  e.ca);
        chk("led_b", e.edge_n, 26'(led_b), 26'(e.lb));
        chk("cnt_b", e.edge_n, u_b.cnt_q,  e.cb);
        chk("led_c", e.edge_n, 26'(led_c), 26'(e.lc));
        chk("cnt_c", e.edge_n, u_c.cnt_q,  e.cc);
        chk("led_d", e.edge_n, 26'(led_d), 26'(e.ld));
        chk("cnt_d", e.edge_n, u_d.cnt_q,  e.cd);
      end
    end
  end

  // Stimulus: set reset inputs for the coming edge and queue its outcome.
  initial begin
    int wait_cnt;
    #1;
    chk("pwrup_led_a", 0, 26'(led_a), 26'd0);
    chk("pwrup_cnt_a", 0, u_a.cnt_q,  A_INIT);
    chk("pwrup_led_b", 0, 26'(led_b), 26'd0);
    chk("pwrup_cnt_b", 0, u_b.cnt_q,  26'd0);
    chk("pwrup_cnt_c", 0, u_c.cnt_q,  26'd10);
    chk("pwrup_cnt_d", 0, u_d.cnt_q,  26'd0);
    for (int k = 1; k <= NEDGES; k++) begin
      rst_a = (k == 26) || (k == 27);
      rst_b = (k == 12);
      sb_q.push_back(expected(k));
      @(negedge clk);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
